muldiv_hilo: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It executes the MIPS func-coded mult, multu, div, divu, mfhi, mflo, mthi and mtlo operations. The ALU control path handles only single-cycle R-type and immediate operations; this block is its sequential counterpart. It sits beside the ALU in the execute stage and stalls the pipeline while an iterative operation is in flight.

---
 rtl/muldiv_hilo.sv | 150 +++++++++++++++
 tb/tb_muldiv_hilo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             illegal,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;

  // state | meaning
  // IDLE  | waiting for an op; mt/mf handled here
  // RUN   | one multiply/divide iteration per cycle
  // FIX   | sign correction, HI/LO write, done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             op_div, neg_lo, neg_hi, b_zero;

  logic             is_md, legal, accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH+1:0] div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    is_md   = (func[5:2] == 4'b0110);
    legal   = is_md | (func[5:2] == 4'b0100);
    accept  = start & ~busy & legal;
    // func[0] clear selects the signed variant (mult, div)
    a_neg   = a[WIDTH-1] & ~func[0];
    b_neg   = b[WIDTH-1] & ~func[0];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
  end

  always_comb begin
    mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shifted = {acc_hi, acc_lo[WIDTH-1]};
    div_diff    = {1'b0, div_shifted} - {2'b00, opnd};
    prod_fix    = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix     = neg_lo ? -acc_lo : acc_lo;
    rem_fix     = neg_hi ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && is_md) state_nx = S_RUN;
      S_RUN:   if (count == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      count  <= '0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (func == F_MTHI) hi <= a;
            if (func == F_MTLO) lo <= a;
            if (is_md) begin
              op_div <= func[1];
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
              b_zero <= (b == '0);
              count  <= CW'(WIDTH - 1);
              acc_hi <= '0;
              // multiply: opnd = multiplicand, acc_lo = multiplier
              // divide:   opnd = divisor,      acc_lo = dividend (becomes quotient)
              opnd   <= func[1] ? b_mag : a_mag;
              acc_lo <= func[1] ? a_mag : b_mag;
            end
          end
        end
        S_RUN: begin
          if (count != '0) count <= count - CW'(1);
          if (op_div) begin
            if (!div_diff[WIDTH+1]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shifted[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
          if (op_div) begin
            // with a zero divisor the remainder path already holds |a|, so hi restores a
            lo <= b_zero ? {WIDTH{1'b1}} : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign stall   = start & busy & legal;
  assign illegal = start & ~legal;
  assign rd_data = (func == F_MFHI) ? hi : lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed-vector and reference-model bench for muldiv_hilo at WIDTH=32.
module tb_muldiv_hilo;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic rst, start, busy, stall, illegal, done;
  logic [5:0] func;
  logic [W-1:0] a, b, hi, lo, rd_data;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .a(a), .b(b),
    .busy(busy), .stall(stall), .illegal(illegal), .done(done),
    .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op for one cycle; returns at #1 after the accept edge (cycle 1).
  task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; func = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance until done, counting cycles since accept; bounded.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [2*W-1:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    res = '0;
    case (f)
      F_MULT:  res = sx * sy;
      F_MULTU: res = ux * uy;
      F_DIV: begin
        if (y == '0) res = {x, {W{1'b1}}};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[W-1:0], q[W-1:0]};
        end
      end
      F_DIVU: begin
        if (y == '0) res = {x, {W{1'b1}}};
        else res = {x % y, x / y};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  initial begin
    int lat;
    int seen_done;
    logic [5:0] rf;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] exp;

    tbl[0] = '{F_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1] = '{F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{F_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    tbl[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{F_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    tbl[6] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[7] = '{F_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[8] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    tbl[9] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    rst = 1'b1; start = 1'b0; func = F_MFLO; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst = 1'b0;

    // mthi / mtlo / mfhi / mflo
    issue(F_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    issue(F_MTLO, 32'hDEAD_BEEF, 32'd0);
    chk("mtlo_lo", lo, 32'hDEAD_BEEF);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    issue(F_MFHI, 32'd0, 32'd0);
    func = F_MFHI; #1;
    chk("mfhi_rd", rd_data, 32'h1234_5678);
    chk("mf_busy", {31'b0, busy}, 32'd0);
    func = F_MFLO; #1;
    chk("mflo_rd", rd_data, 32'hDEAD_BEEF);

    // stall while busy, illegal while busy, mult presented in the done cycle
    issue(F_MULT, 32'd3, 32'd5);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; func = F_MFHI; #1;
    chk("stall_busy", {31'b0, stall}, 32'd1);
    chk("stall_rd_old_hi", rd_data, 32'h1234_5678);
    func = 6'h3F; #1;
    chk("illegal_busy", {31'b0, illegal}, 32'd1);
    chk("illegal_no_stall", {31'b0, stall}, 32'd0);
    start = 1'b0;
    wait_done(4, lat);
    chk("stall_op_lat", lat, 32'd34);
    chk("stall_op_hi", hi, 32'd0);
    chk("stall_op_lo", lo, 32'd15);
    start = 1'b1; func = F_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; #1;
    chk("done_cycle_no_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_cycle_accept_busy", {31'b0, busy}, 32'd1);
    wait_done(1, lat);
    chk("b2b_lat", lat, 32'd34);
    chk("b2b_hi", hi, 32'hFFFF_FFFE);
    chk("b2b_lo", lo, 32'h0000_0001);

    // illegal func while idle leaves state alone
    @(posedge clk); #1;
    start = 1'b1; func = 6'h3F; a = 32'hAAAA_AAAA; #1;
    chk("illegal_idle", {31'b0, illegal}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("illegal_hi", hi, 32'hFFFF_FFFE);
    chk("illegal_lo", lo, 32'h0000_0001);
    chk("illegal_busy_idle", {31'b0, busy}, 32'd0);

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d_busy_c1", i), {31'b0, busy}, 32'd1);
      wait_done(1, lat);
      chk($sformatf("vec%0d_lat", i), lat, 32'd34);
      chk($sformatf("vec%0d_busy_at_done", i), {31'b0, busy}, 32'd0);
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, tbl[i].lo);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // reset in cycle 10 of a divide aborts it
    issue(F_DIVU, 32'd1000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    chk("abort_no_done", seen_done, 32'd0);

    // random sweep against the reference model
    for (int i = 0; i < 24; i++) begin
      rf = F_MULT + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      exp = model(rf, ra, rb);
      issue(rf, ra, rb);
      wait_done(1, lat);
      chk($sformatf("rnd%0d_lat", i), lat, 32'd34);
      chk($sformatf("rnd%0d_hi f=%h a=%h b=%h", i, rf, ra, rb), hi, exp[2*W-1:W]);
      chk($sformatf("rnd%0d_lo f=%h a=%h b=%h", i, rf, ra, rb), lo, exp[W-1:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
